// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMem.
// Per-port fields are packed [1:0] arrays indexed by port number.
interface data_mem_arbiter_if;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       write;
  logic [1:0][2:0]  strobe;
  logic [1:0]       gnt;
  logic [1:0]       ack;
  logic [1:0]       err;
  logic [1:0][31:0] rdata;
  logic             busy;
  logic [31:0]      address;
  logic [31:0]      write_data_m;
  logic [2:0]       strobe_m;
  logic             mem_write_m;
  logic [31:0]      read_data_m;

  modport slave (
    input  req, addr, wdata, write, strobe, read_data_m,
    output gnt, ack, err, rdata, busy, address, write_data_m, strobe_m, mem_write_m
  );

  modport master (
    output req, addr, wdata, write, strobe, read_data_m,
    input  gnt, ack, err, rdata, busy, address, write_data_m, strobe_m, mem_write_m
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of DataMem: arbitrate, check, issue one
// memory cycle, then answer with a registered ack, read data and error flag.
module data_mem_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int ADDR_LIMIT    = 512,
  parameter int ALIGN_CHECK   = 1
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  state_t           state_next;

  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic             write_p0;
  logic [2:0]       strobe_p0;
  logic             err_p0;
  logic             win_p0;
  logic             last_gnt;

  logic [1:0][31:0] rdata_p1;
  logic [1:0]       err_p1;

  logic             arb_en;
  logic             any_req;
  logic             win_next;

  function automatic logic [2:0] nbytes_of(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 3'd1;
      3'b001, 3'b101: return 3'd2;
      default:        return 3'd4;
    endcase
  endfunction

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  function automatic logic access_err(input logic [31:0] a, input logic [2:0] s);
    logic [2:0]  n;
    logic [32:0] sum;
    logic        range_bad;
    logic        align_bad;
    n         = nbytes_of(s);
    sum       = {1'b0, a} + {30'd0, n};
    range_bad = (sum > 33'(ADDR_LIMIT));
    align_bad = (ALIGN_CHECK != 0) &&
                (((n == 3'd2) && a[0]) || ((n == 3'd4) && (a[1:0] != 2'b00)));
    return range_bad || align_bad;
  endfunction

  always_comb begin
    arb_en   = (state != ACCESS);
    any_req  = |bus.req;
    win_next = bus.req[1];
    if (&bus.req) win_next = (PRIORITY_MODE != 0) ? 1'b0 : ~last_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: state_next = any_req ? ACCESS : IDLE;
      ACCESS:     state_next = RESP;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt         = 2'b00;
    bus.ack         = 2'b00;
    bus.mem_write_m = 1'b0;
    bus.busy        = (state != IDLE);
    if (state == ACCESS) begin
      bus.gnt[win_p0] = 1'b1;
      bus.mem_write_m = write_p0 & ~err_p0;
    end
    if (state == RESP) bus.ack[win_p0] = 1'b1;
  end

  // p0: command latched at arbitration; p1: response captured at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0   <= '0;
      wdata_p0  <= '0;
      write_p0  <= 1'b0;
      strobe_p0 <= '0;
      err_p0    <= 1'b0;
      win_p0    <= 1'b0;
      last_gnt  <= 1'b1;
      rdata_p1  <= '0;
      err_p1    <= '0;
    end else begin
      if (arb_en && any_req) begin
        addr_p0   <= bus.addr[win_next];
        wdata_p0  <= bus.wdata[win_next];
        write_p0  <= bus.write[win_next];
        strobe_p0 <= bus.strobe[win_next];
        err_p0    <= access_err(bus.addr[win_next], bus.strobe[win_next]);
        win_p0    <= win_next;
        last_gnt  <= win_next;
      end
      if (state == ACCESS) begin
        rdata_p1[win_p0] <= (write_p0 | err_p0) ? 32'd0 : bus.read_data_m;
        err_p1[win_p0]   <= err_p0;
      end
    end
  end

  assign bus.address      = addr_p0;
  assign bus.write_data_m = wdata_p0;
  assign bus.strobe_m     = strobe_p0;
  assign bus.rdata        = rdata_p1;
  assign bus.err          = err_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: big-endian DataMem model, scoreboard of expected
// acks popped by a monitor, plus a fixed-priority instance for starvation.
module tb_data_mem_arbiter;

  logic clk;
  logic rst;

  data_mem_arbiter_if ba ();
  data_mem_arbiter_if bp ();

  data_mem_arbiter #(.PRIORITY_MODE(0), .ADDR_LIMIT(512), .ALIGN_CHECK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  data_mem_arbiter #(.PRIORITY_MODE(1), .ADDR_LIMIT(512), .ALIGN_CHECK(1)) dut_prio (
    .clk (clk),
    .rst (rst),
    .bus (bp.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DataMem model: byte-addressed, big-endian, synchronous write, combinational read.
  logic [7:0] mem [0:511] = '{default: 8'h00};
  logic [8:0] ma;

  always @(posedge clk) begin
    if (ba.mem_write_m) begin
      case (ba.strobe_m[1:0])
        2'b00: mem[ba.address[8:0]] <= ba.write_data_m[7:0];
        2'b01: begin
          mem[ba.address[8:0]]        <= ba.write_data_m[15:8];
          mem[ba.address[8:0] + 9'd1] <= ba.write_data_m[7:0];
        end
        default: begin
          mem[ba.address[8:0]]        <= ba.write_data_m[31:24];
          mem[ba.address[8:0] + 9'd1] <= ba.write_data_m[23:16];
          mem[ba.address[8:0] + 9'd2] <= ba.write_data_m[15:8];
          mem[ba.address[8:0] + 9'd3] <= ba.write_data_m[7:0];
        end
      endcase
    end
  end

  always_comb begin
    ma = ba.address[8:0];
    case (ba.strobe_m)
      3'b000:  ba.read_data_m = {{24{mem[ma][7]}}, mem[ma]};
      3'b001:  ba.read_data_m = {{16{mem[ma][7]}}, mem[ma], mem[ma + 9'd1]};
      3'b100:  ba.read_data_m = {24'd0, mem[ma]};
      3'b101:  ba.read_data_m = {16'd0, mem[ma], mem[ma + 9'd1]};
      default: ba.read_data_m = {mem[ma], mem[ma + 9'd1], mem[ma + 9'd2], mem[ma + 9'd3]};
    endcase
  end

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (!rst && ba.ack != 2'b00) begin
      p = ba.ack[1] ? 1 : 0;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, ba.ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", p, e.port);
        check("ack_err", {31'd0, ba.err[p]}, {31'd0, e.err});
        check("ack_rdata", ba.rdata[p], e.rdata);
      end
    end
  end

  task automatic drive(input int p, input logic wr, input logic [2:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    ba.req[p]    = 1'b1;
    ba.write[p]  = wr;
    ba.strobe[p] = st;
    ba.addr[p]   = a;
    ba.wdata[p]  = d;
  endtask

  // Returns in the grant (ACCESS) cycle with Req already dropped.
  task automatic issue(input int p, input logic wr, input logic [2:0] st,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e, input logic [31:0] rd, output int lat);
    exp_t x;
    x.port = p; x.err = e; x.rdata = rd;
    exp_q.push_back(x);
    drive(p, wr, st, a, d);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ba.gnt[p] && lat < 20);
    ba.req[p] = 1'b0;
  endtask

  task automatic next_ack(input string name, input int p);
    @(posedge clk); #1;
    check(name, {30'd0, ba.ack}, (p == 0) ? 32'd1 : 32'd2);
  endtask

  int lat;
  int n_gnt;
  exp_t x;

  initial begin
    rst = 1'b1;
    ba.req = '0; ba.addr = '0; ba.wdata = '0; ba.write = '0; ba.strobe = '0;
    bp.req = '0; bp.addr = '0; bp.wdata = '0; bp.write = '0; bp.strobe = '0;
    bp.read_data_m = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {30'd0, ba.gnt}, 32'd0);
    check("rst_ack", {30'd0, ba.ack}, 32'd0);
    check("rst_busy", {31'd0, ba.busy}, 32'd0);
    check("rst_memwrite", {31'd0, ba.mem_write_m}, 32'd0);
    check("rst_rdata0", ba.rdata[0], 32'd0);
    check("rst_err", {30'd0, ba.err}, 32'd0);
    check("rst_address", ba.address, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: store word through port 0
    issue(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'd0, lat);
    check("t1_gnt_lat", lat, 1);
    check("t1_memwrite", {31'd0, ba.mem_write_m}, 32'd1);
    check("t1_address", ba.address, 32'h100);
    check("t1_busy", {31'd0, ba.busy}, 32'd1);
    next_ack("t1_ack", 0);
    check("t1_memwrite_off", {31'd0, ba.mem_write_m}, 32'd0);
    check("t1_mem", word_at(32'h100), 32'hDEADBEEF);

    // T2: port 1 loads, issued back-to-back from the RESP cycle
    issue(1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 32'hDEADBEEF, lat);
    check("t2_lw_lat", lat, 1);
    next_ack("t2_lw_ack", 1);
    issue(1, 1'b0, 3'b000, 32'h100, 32'd0, 1'b0, 32'hFFFFFFDE, lat);
    check("t2_lb_lat", lat, 1);
    next_ack("t2_lb_ack", 1);
    @(posedge clk); #1;
    check("t2_idle", {31'd0, ba.busy}, 32'd0);

    // T3: both held continuously; last grant was port 1, so order is 0,1,0,1
    x.err = 1'b0;
    x.port = 0; x.rdata = 32'hDEADBEEF; exp_q.push_back(x);
    x.port = 1; x.rdata = 32'h0000BEEF; exp_q.push_back(x);
    x.port = 0; x.rdata = 32'hDEADBEEF; exp_q.push_back(x);
    x.port = 1; x.rdata = 32'h0000BEEF; exp_q.push_back(x);
    drive(0, 1'b0, 3'b010, 32'h100, 32'd0);
    drive(1, 1'b0, 3'b101, 32'h102, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("t3_gnt", {30'd0, ba.gnt}, (k % 2 == 0) ? 32'd0 : ((k % 4 == 1) ? 32'd1 : 32'd2));
      check("t3_ack", {30'd0, ba.ack}, (k % 2 == 1) ? 32'd0 : ((k % 4 == 2) ? 32'd1 : 32'd2));
      if (k == 7) ba.req = 2'b00;
    end
    @(posedge clk); #1;
    check("t3_idle", {31'd0, ba.busy}, 32'd0);

    // T4: fixed priority starves port 1
    bp.req = 2'b11;
    bp.write = 2'b00;
    bp.strobe[0] = 3'b010; bp.strobe[1] = 3'b010;
    bp.addr[0] = 32'h0;    bp.addr[1] = 32'h4;
    n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 10; c++) begin
      @(posedge clk); #1;
      if (bp.gnt != 2'b00) begin
        n_gnt++;
        check("t4_gnt", {30'd0, bp.gnt}, 32'd1);
      end
    end
    bp.req = 2'b00;
    check("t4_count", n_gnt, 10);
    repeat (2) @(posedge clk);
    #1;

    // T5: error cases plus the legal range boundary
    issue(0, 1'b1, 3'b001, 32'h101, 32'h00001111, 1'b1, 32'd0, lat);
    check("t5_sh_memwrite", {31'd0, ba.mem_write_m}, 32'd0);
    next_ack("t5_sh_ack", 0);
    check("t5_sh_mem", word_at(32'h100), 32'hDEADBEEF);
    issue(0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 1'b1, 32'd0, lat);
    check("t5_lw_memwrite", {31'd0, ba.mem_write_m}, 32'd0);
    next_ack("t5_lw_ack", 0);
    check("t5_rdata1_held", ba.rdata[1], 32'h0000BEEF);
    issue(1, 1'b1, 3'b010, 32'h1FE, 32'h22222222, 1'b1, 32'd0, lat);
    check("t5_sw_memwrite", {31'd0, ba.mem_write_m}, 32'd0);
    next_ack("t5_sw_ack", 1);
    check("t5_sw_mem", {16'd0, mem[510], mem[511]}, 32'd0);
    issue(1, 1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D, 1'b0, 32'd0, lat);
    check("t5_edge_memwrite", {31'd0, ba.mem_write_m}, 32'd1);
    next_ack("t5_edge_ack", 1);
    check("t5_edge_mem", word_at(32'h1FC), 32'hCAFEF00D);
    @(posedge clk); #1;

    // T6: reset during ACCESS aborts the store
    drive(0, 1'b1, 3'b010, 32'h100, 32'h12345678);
    @(posedge clk); #1;
    check("t6_gnt", {30'd0, ba.gnt}, 32'd1);
    check("t6_memwrite_on", {31'd0, ba.mem_write_m}, 32'd1);
    ba.req = 2'b00;
    rst = 1'b1;
    #1;
    check("t6_memwrite_off", {31'd0, ba.mem_write_m}, 32'd0);
    check("t6_busy", {31'd0, ba.busy}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t6_no_ack", {30'd0, ba.ack}, 32'd0);
    check("t6_mem", word_at(32'h100), 32'hDEADBEEF);
    x.err = 1'b0;
    x.port = 0; x.rdata = 32'hDEADBEEF; exp_q.push_back(x);
    x.port = 1; x.rdata = 32'hFFFFFFDE; exp_q.push_back(x);
    drive(0, 1'b0, 3'b010, 32'h100, 32'd0);
    drive(1, 1'b0, 3'b000, 32'h100, 32'd0);
    @(posedge clk); #1;
    check("t6_tie_gnt", {30'd0, ba.gnt}, 32'd1);
    ba.req[0] = 1'b0;
    @(posedge clk); #1;
    check("t6_ack0", {30'd0, ba.ack}, 32'd1);
    @(posedge clk); #1;
    check("t6_gnt1", {30'd0, ba.gnt}, 32'd2);
    ba.req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
